// File: rtl/reg_bus_arbiter.sv
// ---------------------------------------------------------------------------
// reg_bus_arbiter
//
// Shares one downstream register-interface port between NumReq requesters.
// Requests are granted one at a time in round-robin order. A granted
// transaction owns the downstream port until the slave signals ready, or
// until TimeoutCycles busy cycles have elapsed. A timeout terminates the
// transaction locally with an error response (the downstream access is
// abandoned).
//
// Parameters
//   NumReq        number of requesters (2..8)
//   AddrWidth     register address width
//   DataWidth     data width (byte strobes are DataWidth/8 wide)
//   TimeoutCycles busy cycles before a forced error completion, 0 = never
//
// Ports
//   clk_i, rst_i       clock, asynchronous active-high reset
//   req_valid_i        per-requester request valid
//   req_write_i        per-requester write (1) / read (0)
//   req_addr_i         packed addresses, requester i at slice i
//   req_wdata_i        packed write data
//   req_wstrb_i        packed byte strobes
//   rsp_ready_o        one-hot completion pulse to the granted requester
//   rsp_rdata_o        read data, qualified by rsp_ready_o
//   rsp_error_o        error flag, qualified by rsp_ready_o
//   reg_valid_o ..     downstream request (valid/write/addr/wdata/wstrb)
//   reg_ready_i ..     downstream response (ready/rdata/error)
//   busy_o             a transaction currently owns the downstream port
//   grant_idx_o        index of the current or most recent grant
//   timeout_o          one-cycle pulse on a timeout completion
// ---------------------------------------------------------------------------
module reg_bus_arbiter #(
  parameter int NumReq        = 2,
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 255
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NumReq-1:0]                   req_valid_i,
  input  logic [NumReq-1:0]                   req_write_i,
  input  logic [NumReq*AddrWidth-1:0]         req_addr_i,
  input  logic [NumReq*DataWidth-1:0]         req_wdata_i,
  input  logic [NumReq*(DataWidth/8)-1:0]     req_wstrb_i,
  output logic [NumReq-1:0]                   rsp_ready_o,
  output logic [DataWidth-1:0]                rsp_rdata_o,
  output logic                                rsp_error_o,
  output logic                                reg_valid_o,
  output logic                                reg_write_o,
  output logic [AddrWidth-1:0]                reg_addr_o,
  output logic [DataWidth-1:0]                reg_wdata_o,
  output logic [DataWidth/8-1:0]              reg_wstrb_o,
  input  logic                                reg_ready_i,
  input  logic [DataWidth-1:0]                reg_rdata_i,
  input  logic                                reg_error_i,
  output logic                                busy_o,
  output logic [$clog2(NumReq)-1:0]           grant_idx_o,
  output logic                                timeout_o
);

  localparam int StrbWidth = DataWidth / 8;
  localparam int IdxW      = $clog2(NumReq);
  localparam int CntW      = ($clog2(TimeoutCycles + 1) < 1) ? 1 : $clog2(TimeoutCycles + 1);
  localparam bit TimeoutEn = (TimeoutCycles != 0);

  // Busy-cycle count at which an unanswered transaction is forced to complete.
  localparam logic [CntW-1:0] CntLast  = CntW'(TimeoutEn ? TimeoutCycles - 1 : 0);
  localparam logic [CntW-1:0] CntSat   = {CntW{1'b1}};
  localparam logic [IdxW-1:0] LastInit = IdxW'(NumReq - 1);
  localparam logic [IdxW:0]   NumReqX  = (IdxW + 1)'(NumReq);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

  logic [0:0]      state;
  logic [IdxW-1:0] grant;
  logic [IdxW-1:0] last_grant;
  logic [CntW-1:0] cnt;

  logic            winner_valid;
  logic [IdxW-1:0] winner;
  logic            in_busy;
  logic            ready_hit;
  logic            timeout_hit;
  logic            complete;

  // Unpacked views of the packed request buses so the downstream mux can
  // index directly by the grant register.
  logic [AddrWidth-1:0] addr_arr  [NumReq];
  logic [DataWidth-1:0] wdata_arr [NumReq];
  logic [StrbWidth-1:0] wstrb_arr [NumReq];

  for (genvar g = 0; g < NumReq; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr_i[g*AddrWidth +: AddrWidth];
    assign wdata_arr[g] = req_wdata_i[g*DataWidth +: DataWidth];
    assign wstrb_arr[g] = req_wstrb_i[g*StrbWidth +: StrbWidth];
  end

  // Round-robin search: candidates are visited starting one past the last
  // completed grant, wrapping modulo NumReq. The candidate index carries one
  // spare bit so last_grant + offset never overflows before the wrap.
  always_comb begin : rr_search
    logic [IdxW:0] cand;
    winner_valid = 1'b0;
    winner       = '0;
    cand         = '0;
    for (int off = 1; off <= NumReq; off++) begin
      cand = {1'b0, last_grant} + (IdxW + 1)'(off);
      if (cand >= NumReqX) begin
        cand = cand - NumReqX;
      end
      if (!winner_valid && req_valid_i[cand[IdxW-1:0]]) begin
        winner_valid = 1'b1;
        winner       = cand[IdxW-1:0];
      end
    end
  end

  assign in_busy     = (state == StBusy);
  assign ready_hit   = in_busy && reg_ready_i;
  // A ready in the same cycle as the timeout takes precedence.
  assign timeout_hit = in_busy && !reg_ready_i && TimeoutEn && (cnt == CntLast);
  assign complete    = ready_hit || timeout_hit;

  // Control state: arbitration, grant ownership and busy-cycle counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= StIdle;
      grant      <= '0;
      last_grant <= LastInit;
      cnt        <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (winner_valid) begin
            grant <= winner;
            cnt   <= '0;
            state <= StBusy;
          end
        end
        StBusy: begin
          if (complete) begin
            last_grant <= grant;
            state      <= StIdle;
          end else if (cnt != CntSat) begin
            cnt <= cnt + CntW'(1);
          end
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

  // Downstream request: driven from the granted requester only while busy,
  // otherwise held at zero.
  always_comb begin
    reg_valid_o = 1'b0;
    reg_write_o = 1'b0;
    reg_addr_o  = '0;
    reg_wdata_o = '0;
    reg_wstrb_o = '0;
    if (in_busy) begin
      reg_valid_o = 1'b1;
      reg_write_o = req_write_i[grant];
      reg_addr_o  = addr_arr[grant];
      reg_wdata_o = wdata_arr[grant];
      reg_wstrb_o = wstrb_arr[grant];
    end
  end

  // Upstream response: a zero-latency pass-through of the slave response on
  // a normal completion, or a locally generated error on a timeout.
  always_comb begin
    rsp_ready_o = '0;
    rsp_rdata_o = '0;
    rsp_error_o = 1'b0;
    timeout_o   = 1'b0;
    if (ready_hit) begin
      rsp_ready_o[grant] = 1'b1;
      rsp_rdata_o        = reg_rdata_i;
      rsp_error_o        = reg_error_i;
    end else if (timeout_hit) begin
      rsp_ready_o[grant] = 1'b1;
      rsp_error_o        = 1'b1;
      timeout_o          = 1'b1;
    end
  end

  assign busy_o      = in_busy;
  assign grant_idx_o = grant;

endmodule

// File: doc/reg_bus_arbiter.md
# reg_bus_arbiter

Round-robin arbiter that shares one peripheral register-interface port (valid/ready request, single-beat response) between `NumReq` requesters, e.g. the bus-subsystem register bridge and a debug/DMA master feeding the SoC controller, fast interrupt controller and UART slaves. It serializes transactions, holds the grant until the downstream slave completes, and terminates hung transactions with an error after a programmable timeout.

## Interface
- `NumReq`, default 2: number of requesters (2..8).
- `AddrWidth`, default 32: register address width.
- `DataWidth`, default 32: data width; strobe width is `DataWidth/8`.
- `TimeoutCycles`, default 255: maximum busy cycles before forced error completion; 0 disables the timeout.

- `clk_i`  in  1  clock; the only clock domain.
- `rst_i`  in  1  asynchronous, active-high reset.
- `req_valid_i`  in  NumReq  per-requester request valid.
- `req_write_i`  in  NumReq  per-requester write (1) / read (0).
- `req_addr_i`  in  NumReq*AddrWidth  packed addresses, requester i at slice i.
- `req_wdata_i`  in  NumReq*DataWidth  packed write data.
- `req_wstrb_i`  in  NumReq*DataWidth/8  packed byte strobes.
- `rsp_ready_o`  out  NumReq  one-hot completion pulse to the granted requester.
- `rsp_rdata_o`  out  DataWidth  shared read data; valid only with a `rsp_ready_o` bit.
- `rsp_error_o`  out  1  error flag qualifying `rsp_ready_o`.
- `reg_valid_o`, `reg_write_o`, `reg_addr_o`, `reg_wdata_o`, `reg_wstrb_o`  out  1/1/AddrWidth/DataWidth/DataWidth/8  downstream request.
- `reg_ready_i`, `reg_rdata_i`, `reg_error_i`  in  1/DataWidth/1  downstream response.
- `busy_o`  out  1  high in BUSY.
- `grant_idx_o`  out  $clog2(NumReq)  index of the current or last grant.
- `timeout_o`  out  1  one-cycle pulse on a timeout completion.

## Operation
- FSM with two states: IDLE and BUSY.
- IDLE: if any `req_valid_i` bit is set, pick a winner by round-robin search starting at `(last_grant+1) mod NumReq`. Register the winner in `grant`, clear `cnt`, and go to BUSY. Otherwise stay in IDLE.
- BUSY: `reg_valid_o`=1. Request fields are muxed combinationally from requester `grant`.
  - `reg_ready_i`=1: assert `rsp_ready_o[grant]`. Forward `reg_rdata_i` and `reg_error_i`. Set `last_grant<=grant` and go to IDLE.
  - Else, if `TimeoutCycles`≠0 and `cnt==TimeoutCycles-1`: assert `rsp_ready_o[grant]`, `rsp_error_o`=1, `rsp_rdata_o`=0 and `timeout_o`. Set `last_grant<=grant` and go to IDLE. The downstream transaction is abandoned.
  - Else `cnt<=cnt+1`.
- `reg_ready_i` and the timeout condition in the same cycle: ready wins and completion is normal.
- Outside a completion cycle: `rsp_ready_o`=0, `rsp_rdata_o`=0, `rsp_error_o`=0.
- In IDLE, `reg_valid_o`=0 and all downstream fields are 0.
- Requesters must hold valid and fields stable until their `rsp_ready_o`. If the granted requester drops valid mid-BUSY, the transaction still completes and the `rsp_ready_o` pulse is issued.
- `cnt` width is $clog2(TimeoutCycles+1), minimum 1. It saturates and never wraps.
- Reset: state IDLE, `grant`=0, `last_grant`=NumReq-1 (requester 0 wins first), `cnt`=0. All outputs are 0.

## Timing
- A request seen in IDLE at cycle 0 drives `reg_valid_o` at cycle 1 (one-cycle arbitration latency).
- `reg_ready_i` at cycle k produces `rsp_ready_o` combinationally at cycle k, with zero response latency. State is IDLE at k+1.
- Best-case throughput is one transaction per 2 cycles, because IDLE always occupies at least one cycle between grants.
- Timeout fires on the `TimeoutCycles`-th consecutive BUSY cycle without ready, i.e. cycle `TimeoutCycles` after the grant cycle.
- Requests arriving while BUSY are not granted until the next IDLE cycle.
- Reset asserted mid-BUSY returns the block to reset values immediately and asynchronously. No `rsp_ready_o` pulse is generated.

## Test plan
- Single read: req0 valid at cycle 0, addr 0x10, slave ready at cycle 3 with rdata 0xDEADBEEF. Required: `reg_valid_o` high on cycles 1–3; `rsp_ready_o`=01 with rdata 0xDEADBEEF at cycle 3; `busy_o` low at 4.
- Fairness: req0 and req1 held continuously and the slave always ready. Required grant order is 0,1,0,1 with completions at cycles 1,3,5,7.
- Write fields: req1 write, addr 0x24, wdata 0x5A5A5A5A, wstrb 0x3. Required: exactly these values on the `reg_*` outputs while BUSY, and `reg_write_o`=1.
- Timeout: `TimeoutCycles`=4 and the slave never ready. Required: `rsp_ready_o[grant]`, `rsp_error_o`, `timeout_o` and rdata 0 all at cycle 4 after the grant; IDLE at the next cycle.
- Ready/timeout collision: the slave asserts ready with `reg_error_i`=0 exactly on the timeout cycle. Required: normal completion, `rsp_error_o`=0, `timeout_o`=0.
- Reset mid-BUSY: assert `rst_i` at the second BUSY cycle. Required: all outputs 0 immediately; after release, the next grant goes to requester 0.
